// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register slice.
//   mode_t  : 3-bit operation code carried on cmd_mode
//   state_t : two-state controller (IDLE accepts commands, RUN steps)
//   MODE_W  : width of the operation code field
//   is_stepped_mode() : true for the shift/rotate modes that take cmd_count
//                       single-bit steps, false for the immediate modes
// ---------------------------------------------------------------------------
package usr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHR   = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_LOAD  = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_ROL   = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // HOLD, LOAD and CLEAR complete at the accepting edge; everything else
  // is a shift or rotate that walks through cmd_count steps.
  function automatic logic is_stepped_mode(input mode_t mode);
    logic stepped;
    case (mode)
      MODE_HOLD, MODE_LOAD, MODE_CLEAR: stepped = 1'b0;
      default:                          stepped = 1'b1;
    endcase
    return stepped;
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// ---------------------------------------------------------------------------
// usr_step_logic
// Purely combinational next-value selection for one single-bit step of the
// universal shift register.
//   q       [WIDTH-1:0] : current register contents
//   mode    mode_t      : captured operation code
//   d_right             : serial bit entering the MSB on SHR
//   d_left              : serial bit entering the LSB on SHL
//   next_q  [WIDTH-1:0] : contents after one step of the given mode
// Immediate modes (HOLD/LOAD/CLEAR) never reach the RUN state, so here they
// simply pass q through.
// ---------------------------------------------------------------------------
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             d_right,
  input  logic             d_left,
  output logic [WIDTH-1:0] next_q
);

  // One step per mode. Rotates feed the outgoing bit back in at the other
  // end so nothing is lost; ASR replicates the sign bit into the MSB.
  always_comb begin
    next_q = q;
    case (mode)
      MODE_SHR: next_q = {d_right, q[WIDTH-1:1]};
      MODE_SHL: next_q = {q[WIDTH-2:0], d_left};
      MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
      MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR: next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// ---------------------------------------------------------------------------
// universal_shift_register_n
// WIDTH-bit universal shift register with a valid/ready command port and a
// multi-cycle engine for shift/rotate counts.
//   clk, reset (sync, active-low)
//   cmd_valid / cmd_ready : command handshake, accepted when both high
//   cmd_mode  [2:0]       : HOLD SHR SHL LOAD ROR ROL ASR CLEAR
//   cmd_count [CNT_W-1:0] : number of single-bit steps for shift/rotate
//   d_parallel[WIDTH-1:0] : LOAD data
//   d_right / d_left      : serial inputs, sampled live on every step
//   abort                 : ends a running operation without a step or done
//   q_parallel            : register contents
//   q_serial_lsb / _msb   : q_parallel[0] / q_parallel[WIDTH-1]
//   busy                  : RUN state
//   done                  : one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_register_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] d_parallel,
  input  logic             d_right,
  input  logic             d_left,
  input  logic             abort,
  output logic [WIDTH-1:0] q_parallel,
  output logic             q_serial_lsb,
  output logic             q_serial_msb,
  output logic             busy,
  output logic             done
);

  state_t           state;
  mode_t            mode_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] step_q;
  mode_t            cmd_mode_e;

  assign cmd_mode_e = mode_t'(cmd_mode);

  usr_step_logic #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q),
    .mode    (mode_r),
    .d_right (d_right),
    .d_left  (d_left),
    .next_q  (step_q)
  );

  // Controller and datapath. In IDLE a command is taken whenever cmd_valid
  // is high (cmd_ready is exactly the IDLE state). Immediate modes finish at
  // the accepting edge; a stepped mode with a zero count is treated the same
  // way as HOLD. In RUN each edge applies one step until the last one, where
  // done is raised for the following cycle so the next command can be taken
  // straight away. abort drops back to IDLE keeping q and suppressing done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q         <= '0;
      state     <= ST_IDLE;
      remaining <= '0;
      done      <= 1'b0;
      mode_r    <= MODE_HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode_r <= cmd_mode_e;
            if (is_stepped_mode(cmd_mode_e) && (cmd_count != '0)) begin
              state     <= ST_RUN;
              remaining <= cmd_count;
            end else begin
              done <= 1'b1;
              if (cmd_mode_e == MODE_LOAD) begin
                q <= d_parallel;
              end else if (cmd_mode_e == MODE_CLEAR) begin
                q <= '0;
              end
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            remaining <= '0;
          end else begin
            q         <= step_q;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and serial taps are direct decodes of the registered state.
  always_comb begin
    cmd_ready    = (state == ST_IDLE);
    busy         = (state == ST_RUN);
    q_parallel   = q;
    q_serial_lsb = q[0];
    q_serial_msb = q[WIDTH-1];
  end

endmodule

// File: tb/tb_universal_shift_register_n.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register_n
// Directed bench for universal_shift_register_n at WIDTH=8, CNT_W=4.
// Expected values are hand-computed from the mode definitions.
// ---------------------------------------------------------------------------
module tb_universal_shift_register_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_SHR   = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_LOAD  = 3'd3;
  localparam logic [2:0] M_ROR   = 3'd4;
  localparam logic [2:0] M_ROL   = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] d_parallel;
  logic             d_right;
  logic             d_left;
  logic             abort;
  logic [WIDTH-1:0] q_parallel;
  logic             q_serial_lsb;
  logic             q_serial_msb;
  logic             busy;
  logic             done;

  int checkCount = 0;
  int passCount  = 0;

  universal_shift_register_n #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_count    (cmd_count),
    .d_parallel   (d_parallel),
    .d_right      (d_right),
    .d_left       (d_left),
    .abort        (abort),
    .q_parallel   (q_parallel),
    .q_serial_lsb (q_serial_lsb),
    .q_serial_msb (q_serial_msb),
    .busy         (busy),
    .done         (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accepting edge, then withdraw it.
  task automatic applyStimulus(input logic [2:0] mode, input logic [CNT_W-1:0] count,
                               input logic [WIDTH-1:0] data);
    cmd_valid  = 1'b1;
    cmd_mode   = mode;
    cmd_count  = count;
    d_parallel = data;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_mode   = M_HOLD;
    cmd_count  = '0;
    d_parallel = '0;
    d_right    = 1'b0;
    d_left     = 1'b0;
    abort      = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    checkOutput("rst_q",     q_parallel,   8'h00);
    checkOutput("rst_ready", cmd_ready,    1'b1);
    checkOutput("rst_busy",  busy,         1'b0);
    checkOutput("rst_done",  done,         1'b0);
    checkOutput("rst_lsb",   q_serial_lsb, 1'b0);
    checkOutput("rst_msb",   q_serial_msb, 1'b0);

    // LOAD 0xA5: immediate, one-cycle done, ready stays high
    applyStimulus(M_LOAD, 4'd0, 8'hA5);
    checkOutput("load_q",     q_parallel, 8'hA5);
    checkOutput("load_done",  done,       1'b1);
    checkOutput("load_ready", cmd_ready,  1'b1);
    checkOutput("load_lsb",   q_serial_lsb, 1'b1);
    tick();
    checkOutput("load_done_drop", done, 1'b0);

    // SHR x3 with d_right=1: A5 -> D2 -> E9 -> F4
    d_right = 1'b1;
    applyStimulus(M_SHR, 4'd3, 8'h00);
    checkOutput("shr_acc_q",    q_parallel, 8'hA5);
    checkOutput("shr_acc_busy", busy,       1'b1);
    checkOutput("shr_acc_rdy",  cmd_ready,  1'b0);
    tick();
    checkOutput("shr_s1_q", q_parallel, 8'hD2);
    tick();
    checkOutput("shr_s2_q",    q_parallel, 8'hE9);
    checkOutput("shr_s2_busy", busy,       1'b1);
    checkOutput("shr_s2_done", done,       1'b0);
    tick();
    checkOutput("shr_q",    q_parallel, 8'hF4);
    checkOutput("shr_done", done,       1'b1);
    checkOutput("shr_busy", busy,       1'b0);
    d_right = 1'b0;
    tick();
    checkOutput("shr_done_drop", done, 1'b0);

    // ROL x9 on 0x81: after 8 steps back to 0x81, after 9 it is 0x03
    applyStimulus(M_LOAD, 4'd0, 8'h81);
    applyStimulus(M_ROL, 4'd9, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("rol_s8_q",    q_parallel, 8'h81);
    checkOutput("rol_s8_busy", busy,       1'b1);
    tick();
    checkOutput("rol_q",    q_parallel, 8'h03);
    checkOutput("rol_done", done,       1'b1);

    // ASR x2 on 0x90: C8 -> E4, sign bit replicated
    applyStimulus(M_LOAD, 4'd0, 8'h90);
    applyStimulus(M_ASR, 4'd2, 8'h00);
    tick();
    checkOutput("asr_s1_q", q_parallel, 8'hC8);
    tick();
    checkOutput("asr_q",    q_parallel,   8'hE4);
    checkOutput("asr_done", done,         1'b1);
    checkOutput("asr_msb",  q_serial_msb, 1'b1);
    checkOutput("asr_lsb",  q_serial_lsb, 1'b0);

    // SHL count 0: no change, done next cycle, no RUN
    d_left = 1'b1;
    applyStimulus(M_SHL, 4'd0, 8'h00);
    checkOutput("shl0_q",    q_parallel, 8'hE4);
    checkOutput("shl0_done", done,       1'b1);
    checkOutput("shl0_busy", busy,       1'b0);
    d_left = 1'b0;
    tick();

    // SHL x5 aborted after 2 steps: E4 -> C8 -> 90, then abort
    applyStimulus(M_SHL, 4'd5, 8'h00);
    tick();
    tick();
    checkOutput("abt_s2_q", q_parallel, 8'h90);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abt_q",     q_parallel, 8'h90);
    checkOutput("abt_busy",  busy,       1'b0);
    checkOutput("abt_done",  done,       1'b0);
    checkOutput("abt_ready", cmd_ready,  1'b1);
    tick();
    checkOutput("abt_q_hold",  q_parallel, 8'h90);
    checkOutput("abt_done_2",  done,       1'b0);

    // Back-to-back ROR x1: 90 -> 48, then taken in the done cycle -> 24
    applyStimulus(M_ROR, 4'd1, 8'h00);
    tick();
    checkOutput("b2b_q1",    q_parallel, 8'h48);
    checkOutput("b2b_done1", done,       1'b1);
    checkOutput("b2b_rdy1",  cmd_ready,  1'b1);
    applyStimulus(M_ROR, 4'd1, 8'h00);
    checkOutput("b2b_busy2", busy, 1'b1);
    tick();
    checkOutput("b2b_q2",    q_parallel, 8'h24);
    checkOutput("b2b_done2", done,       1'b1);

    // Held cmd_valid during RUN is taken only once back in IDLE:
    // SHR x2 on 0x24 (d_right=0): 12 -> 09, then LOAD 0x3C
    applyStimulus(M_SHR, 4'd2, 8'h00);
    cmd_valid  = 1'b1;
    cmd_mode   = M_LOAD;
    d_parallel = 8'h3C;
    tick();
    checkOutput("hold_s1_q", q_parallel, 8'h12);
    tick();
    checkOutput("hold_s2_q",    q_parallel, 8'h09);
    checkOutput("hold_s2_done", done,       1'b1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("hold_load_q", q_parallel, 8'h3C);

    // Reset mid-RUN with cmd_valid held: clears, then LOAD taken after release
    applyStimulus(M_ROL, 4'd6, 8'h00);
    tick();
    checkOutput("rrun_s1_q", q_parallel, 8'h78);
    cmd_valid  = 1'b1;
    cmd_mode   = M_LOAD;
    d_parallel = 8'h5A;
    abort      = 1'b1;
    reset      = 1'b0;
    tick();
    checkOutput("rrun_q",    q_parallel, 8'h00);
    checkOutput("rrun_busy", busy,       1'b0);
    checkOutput("rrun_done", done,       1'b0);
    reset = 1'b1;
    abort = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checkOutput("rrun_load_q",    q_parallel, 8'h5A);
    checkOutput("rrun_load_done", done,       1'b1);

    // Abort is ignored in IDLE; CLEAR empties the register
    abort = 1'b1;
    applyStimulus(M_LOAD, 4'd0, 8'h77);
    checkOutput("idle_abort_q", q_parallel, 8'h77);
    abort = 1'b0;
    applyStimulus(M_HOLD, 4'd3, 8'h00);
    checkOutput("hold_q",    q_parallel, 8'h77);
    checkOutput("hold_busy", busy,       1'b0);
    applyStimulus(M_CLEAR, 4'd0, 8'hFF);
    checkOutput("clear_q",    q_parallel, 8'h00);
    checkOutput("clear_done", done,       1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
